debounce_edge: RTL and testbench

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

---
 rtl/debounce_edge.sv | 115 +++++++++++
 tb/tb_debounce_edge.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
// Debounces a single-bit level already registered in the clk domain and reports
// clean rising/falling transitions plus a saturating count of aborted transitions.
module debounce_edge #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                d,
    input  logic                clr,
    output logic                q,
    output logic                rise,
    output logic                fall,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              d_s;
    logic              q_nxt, rise_nxt, fall_nxt, abort;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt = state;
        cnt_nxt   = '0;
        q_nxt     = q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        abort     = 1'b0;

        case (state)
            IDLE_LOW: begin
                if (d_s) begin
                    state_nxt = CHK_HIGH;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CHK_HIGH: begin
                if (!d_s) begin
                    state_nxt = IDLE_LOW;
                    abort     = 1'b1;
                end else if (cnt == LAST_CNT) begin
                    state_nxt = IDLE_HIGH;
                    q_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!d_s) begin
                    state_nxt = CHK_LOW;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CHK_LOW: begin
                if (d_s) begin
                    state_nxt = IDLE_HIGH;
                    abort     = 1'b1;
                end else if (cnt == LAST_CNT) begin
                    state_nxt = IDLE_LOW;
                    q_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                q_nxt     = 1'b0;
            end
        endcase
    end

    // busy is registered from the next state so it tracks the state register exactly.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
        if (!rst_n) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            d_s        <= 1'b0;
            q          <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            busy       <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            d_s   <= d;
            q     <= q_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= (state_nxt == CHK_HIGH) || (state_nxt == CHK_LOW);
            if (clr) begin
                glitch_cnt <= '0;
            end else if (abort && (glitch_cnt != GLITCH_MAX)) begin
                glitch_cnt <= glitch_cnt + GLITCH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: one instance with STABLE_CYCLES=4 and one
// with STABLE_CYCLES=2 for the alternating-input boundary case.
module tb_debounce_edge;

    logic       clk = 1'b0;
    logic       rst_n, d, clr, d2;
    logic       q, rise, fall, busy;
    logic [7:0] glitch_cnt;
    logic       q2, rise2, fall2, busy2;
    logic [7:0] glitch2;

    int n_tests = 0;
    int n_fail  = 0;
    int rise_seen, fall_seen, both_seen;
    int busy_seen, q_seen, q2_seen, rise2_seen, fall2_seen;

    always #5 clk = ~clk;

    debounce_edge #(.STABLE_CYCLES(4), .CNT_W(5), .GLITCH_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .clr(clr),
        .q(q), .rise(rise), .fall(fall), .busy(busy), .glitch_cnt(glitch_cnt)
    );

    debounce_edge #(.STABLE_CYCLES(2), .CNT_W(5), .GLITCH_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .d(d2), .clr(clr),
        .q(q2), .rise(rise2), .fall(fall2), .busy(busy2), .glitch_cnt(glitch2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive d, take one rising edge, then sample outputs 1 time unit later.
    task automatic step(input logic din);
        d = din;
        @(posedge clk);
        #1;
        rise_seen  += int'(rise);
        fall_seen  += int'(fall);
        busy_seen  += int'(busy);
        q_seen     += int'(q);
        q2_seen    += int'(q2);
        rise2_seen += int'(rise2);
        fall2_seen += int'(fall2);
        if (rise && fall) both_seen++;
    endtask

    initial begin
        rst_n = 1'b0; d = 1'b0; clr = 1'b0; d2 = 1'b0;
        rise_seen = 0; fall_seen = 0; both_seen = 0;
        busy_seen = 0; q_seen = 0; q2_seen = 0; rise2_seen = 0; fall2_seen = 0;

        // Reset state
        step(1'b0);
        step(1'b0);
        check("rst_q", q, 0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_busy", busy, 0);
        check("rst_glitch", glitch_cnt, 0);
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);

        // Clean rise: d=1 sampled at E0..E3, q/rise appear after E4
        rise_seen = 0; fall_seen = 0;
        step(1'b1);
        check("rise_e0_busy", busy, 0);
        step(1'b1);
        check("rise_e1_busy", busy, 1);
        step(1'b1);
        step(1'b1);
        check("rise_e3_q", q, 0);
        check("rise_e3_rise", rise, 0);
        step(1'b1);
        check("rise_e4_q", q, 1);
        check("rise_e4_rise", rise, 1);
        check("rise_e4_busy", busy, 0);
        step(1'b1);
        check("rise_e5_rise", rise, 0);
        check("rise_e5_q", q, 1);
        for (int i = 0; i < 3; i++) step(1'b1);
        check("rise_pulses", rise_seen, 1);
        check("rise_no_fall", fall_seen, 0);
        check("rise_glitch", glitch_cnt, 0);

        // Clean fall completes the full cycle
        fall_seen = 0;
        step(1'b0);
        check("fall_f0_q", q, 1);
        step(1'b0);
        check("fall_f1_busy", busy, 1);
        step(1'b0);
        step(1'b0);
        check("fall_f3_q", q, 1);
        check("fall_f3_fall", fall, 0);
        step(1'b0);
        check("fall_f4_q", q, 0);
        check("fall_f4_fall", fall, 1);
        step(1'b0);
        check("fall_f5_fall", fall, 0);
        check("cycle_rise_pulses", rise_seen, 1);
        check("cycle_fall_pulses", fall_seen, 1);

        // Glitch: three high samples then low
        rise_seen = 0; busy_seen = 0; q_seen = 0;
        step(1'b1); step(1'b1); step(1'b1);
        step(1'b0); step(1'b0); step(1'b0);
        check("glitch_busy_cycles", busy_seen, 3);
        check("glitch_q_high", q_seen, 0);
        check("glitch_no_rise", rise_seen, 0);
        check("glitch_cnt_1", glitch_cnt, 1);

        // Reset while in CHK_HIGH with cnt=2, then d held high through release
        step(1'b1); step(1'b1); step(1'b1);
        check("midchk_busy", busy, 1);
        rise_seen = 0;
        rst_n = 1'b0;
        step(1'b1);
        check("midrst_q", q, 0);
        check("midrst_busy", busy, 0);
        check("midrst_glitch", glitch_cnt, 0);
        check("midrst_rise", rise, 0);
        step(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1);
        check("release_r3_q", q, 0);
        step(1'b1);
        check("release_r4_q", q, 1);
        check("release_r4_rise", rise, 1);
        step(1'b1); step(1'b1);
        check("release_rise_pulses", rise_seen, 1);
        for (int i = 0; i < 6; i++) step(1'b0);
        check("release_back_low", q, 0);

        // Saturation: 300 aborted two-sample pulses
        for (int i = 0; i < 300; i++) begin
            step(1'b1); step(1'b1); step(1'b0); step(1'b0);
            if (i == 254) check("sat_255_reached", glitch_cnt, 255);
        end
        check("sat_held", glitch_cnt, 255);
        check("sat_q", q, 0);
        step(1'b1); step(1'b1); step(1'b0);
        clr = 1'b1;
        step(1'b0);
        clr = 1'b0;
        check("clr_beats_abort", glitch_cnt, 0);
        step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        check("count_after_clr", glitch_cnt, 1);

        // STABLE_CYCLES=2, alternating input: every check aborts
        q2_seen = 0; rise2_seen = 0; fall2_seen = 0;
        check("alt_start", glitch2, 0);
        for (int k = 0; k < 20; k++) begin
            d2 = (k % 2 == 0);
            step(1'b0);
            check($sformatf("alt_glitch_e%0d", k), glitch2, k / 2);
        end
        check("alt_q_never", q2_seen, 0);
        check("alt_no_rise", rise2_seen, 0);
        check("alt_no_fall", fall2_seen, 0);

        check("rise_fall_together", both_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
